// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the codec-configuration I2C master:
// FSM state encodings, SCL quarter-phase encodings and the register init table.
`timescale 1ns/1ps
package i2c_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_ADDR  = 4'd2,
        ST_ACK_A = 4'd3,
        ST_HI    = 4'd4,
        ST_ACK_H = 4'd5,
        ST_LO    = 4'd6,
        ST_ACK_L = 4'd7,
        ST_STOP  = 4'd8,
        ST_GAP   = 4'd9,
        ST_DONE  = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        PH_LOW  = 2'd0,
        PH_RISE = 2'd1,
        PH_HIGH = 2'd2,
        PH_FALL = 2'd3
    } phase_e;

    localparam logic [7:0]  CODEC_ADDR = 8'h34;
    localparam int unsigned NUM_WORDS  = 11;

    // Each entry is {reg[6:0], data[8:0]}, so [15:8] is the HI byte and [7:0] the LO byte.
    localparam logic [15:0] INIT_ROM [NUM_WORDS] = '{
        {7'h0F, 9'h000}, {7'h00, 9'h017}, {7'h01, 9'h017}, {7'h02, 9'h079},
        {7'h03, 9'h079}, {7'h04, 9'h012}, {7'h05, 9'h000}, {7'h06, 9'h000},
        {7'h07, 9'h002}, {7'h08, 9'h000}, {7'h09, 9'h001}
    };

    function automatic logic [15:0] rom_word(input logic [3:0] idx);
        logic [15:0] w;
        w = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (idx == 4'(i)) w = INIT_ROM[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator: a 0..CLK_DIV-1 divider that emits qtick on its
// last count, and a 2-bit phase counter that advances on every qtick.
`timescale 1ns/1ps
module i2c_clk_gen
    import i2c_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 31
) (
    input  logic   clk,
    input  logic   reset_n,
    output logic   qtick,
    output phase_e phase
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    phase_e        phase_q, phase_d;

    always_comb begin
        qtick   = (div_q == DIV_LAST);
        div_d   = qtick ? '0 : div_q + DW'(1);
        phase_d = qtick ? phase_e'(phase_q + 2'd1) : phase_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            phase_q <= PH_LOW;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/i2c_state.sv
// Write-only I2C master that loads the codec init table after reset, then idles.
// Optional macro I2C_ACK_RETRY_EN: on NACK, abort with STOP and resend the word (max 3 tries).
`timescale 1ns/1ps
module i2c_state
    import i2c_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 31,
    parameter int unsigned START_DELAY = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       FPGA_I2C_SCLK,
    inout  logic       FPGA_I2C_SDAT,
    output logic       config_done,
    output logic       ack_error,
    output logic [3:0] current_state
);

    localparam logic [3:0] WORDS4   = 4'(NUM_WORDS);
    localparam logic [7:0] DLY_LAST = 8'((START_DELAY > 0) ? START_DELAY - 1 : 0);

    logic   qtick;
    phase_e phase;

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .qtick   (qtick),
        .phase   (phase)
    );

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  dly_q, dly_d;
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] word;
    logic        sda_in;
    logic        period_end;
    logic        ack_slot;
`ifdef I2C_ACK_RETRY_EN
    logic        nack_q, nack_d;
    logic [1:0]  retry_q, retry_d;
`endif

    assign word       = rom_word(idx_q);
    assign sda_in     = FPGA_I2C_SDAT;
    assign period_end = qtick && (phase == PH_FALL);
    assign ack_slot   = (state_q == ST_ACK_A) || (state_q == ST_ACK_H) || (state_q == ST_ACK_L);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        dly_d   = dly_q;
        err_d   = err_q;
`ifdef I2C_ACK_RETRY_EN
        nack_d  = nack_q;
        retry_d = retry_q;
`endif
        // ACK is sampled at the end of the SCL-high quarter, where the line is settled.
        if (qtick && (phase == PH_HIGH) && ack_slot && sda_in) begin
            err_d = 1'b1;
`ifdef I2C_ACK_RETRY_EN
            nack_d = 1'b1;
`endif
        end
        if (period_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (dly_q >= DLY_LAST) state_d = ST_START;
                    else dly_d = dly_q + 8'd1;
                end
                ST_START: begin
                    state_d = ST_ADDR;
                    sh_d    = CODEC_ADDR;
                    bit_d   = '0;
                end
                ST_ADDR, ST_HI, ST_LO: begin
                    sh_d = {sh_q[6:0], 1'b0};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = state_e'(state_q + 4'd1);
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                ST_ACK_A: begin
                    state_d = ST_HI;
                    sh_d    = word[15:8];
`ifdef I2C_ACK_RETRY_EN
                    if (nack_q) state_d = ST_STOP;
`endif
                end
                ST_ACK_H: begin
                    state_d = ST_LO;
                    sh_d    = word[7:0];
`ifdef I2C_ACK_RETRY_EN
                    if (nack_q) state_d = ST_STOP;
`endif
                end
                ST_ACK_L: state_d = ST_STOP;
                ST_STOP: begin
                    state_d = ST_GAP;
`ifdef I2C_ACK_RETRY_EN
                    // Hold the index for a resend unless this was the third failure in a row.
                    if (nack_q && (retry_q != 2'd2)) begin
                        retry_d = retry_q + 2'd1;
                    end else begin
                        retry_d = '0;
                        idx_d   = idx_q + 4'd1;
                    end
                    nack_d = 1'b0;
`else
                    idx_d = idx_q + 4'd1;
`endif
                end
                ST_GAP:  state_d = (idx_q < WORDS4) ? ST_START : ST_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        scl_d  = 1'b1;
        sda_d  = 1'b1;
        done_d = (state_q == ST_DONE);
        case (state_q)
            ST_START: begin
                scl_d = (phase != PH_FALL);
                sda_d = (phase == PH_LOW) || (phase == PH_RISE);
            end
            ST_ADDR, ST_HI, ST_LO: begin
                scl_d = (phase == PH_RISE) || (phase == PH_HIGH);
                sda_d = sh_q[7];
            end
            ST_ACK_A, ST_ACK_H, ST_ACK_L: begin
                scl_d = (phase == PH_RISE) || (phase == PH_HIGH);
            end
            ST_STOP: begin
                scl_d = (phase != PH_LOW);
                sda_d = (phase == PH_HIGH) || (phase == PH_FALL);
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            dly_q   <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef I2C_ACK_RETRY_EN
            nack_q  <= 1'b0;
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            dly_q   <= dly_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef I2C_ACK_RETRY_EN
            nack_q  <= nack_d;
            retry_q <= retry_d;
`endif
        end
    end

    assign FPGA_I2C_SCLK = scl_q;
    assign FPGA_I2C_SDAT = sda_q ? 1'bz : 1'b0;
    assign config_done   = done_q;
    assign ack_error     = err_q;
    assign current_state = state_q;

endmodule

// File: tb/tb_i2c_state.sv
// Bench for i2c_state: bus-level slave model decodes bytes and answers ACK/NACK;
// expected bytes are queued by the stimulus and popped by the slave monitor.
`timescale 1ns/1ps
module tb_i2c_state;

    localparam int unsigned D = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    wire        scl;
    wire        sdat;
    logic       done;
    logic       err;
    logic [3:0] cs;
    logic       ack_drive = 1'b0;

    pullup (sdat);
    assign sdat = ack_drive ? 1'b0 : 1'bz;

    i2c_state #(.CLK_DIV(D), .START_DELAY(1)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .FPGA_I2C_SCLK (scl),
        .FPGA_I2C_SDAT (sdat),
        .config_done   (done),
        .ack_error     (err),
        .current_state (cs)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed {reg[6:0],data[8]} and data[7:0] bytes for each table word.
    logic [7:0] exp_hi [11] = '{8'h1E, 8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h12};
    logic [7:0] exp_lo [11] = '{8'h00, 8'h17, 8'h17, 8'h79, 8'h79, 8'h12, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01};

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endfunction

    task automatic push_word(input int w);
        sb.push_back(8'h34);
        sb.push_back(exp_hi[w]);
        sb.push_back(exp_lo[w]);
    endtask

    // Slave model / monitor
    logic       scl_prev = 1'b1;
    logic       sda_prev = 1'b1;
    logic       in_frame = 1'b0;
    logic       acking = 1'b0;
    int         bitcnt = 0;
    int         byte_num = 0;
    logic [7:0] shreg = '0;
    logic [7:0] exp_b;
    int         n_starts = 0;
    int         n_stops = 0;
    int         last_start_cyc = 0;
    int         nack_frame = -1;

    always @(scl or sdat) begin
        if (scl !== scl_prev) begin
            if (scl === 1'b1) begin
                if (in_frame && !acking && bitcnt < 8) begin
                    shreg = {shreg[6:0], (sdat === 1'b0) ? 1'b0 : 1'b1};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL byte_unexpected: got %02h, expected none", shreg);
                        end else begin
                            exp_b = sb.pop_front();
                            check("byte", {24'h0, shreg}, {24'h0, exp_b});
                        end
                    end
                end
            end else if (in_frame) begin
                if (acking) begin
                    ack_drive = 1'b0;
                    acking    = 1'b0;
                    bitcnt    = 0;
                    byte_num++;
                end else if (bitcnt == 8) begin
                    acking    = 1'b1;
                    ack_drive = !(n_starts == nack_frame && byte_num == 2);
                end
            end
        end else if (sdat !== sda_prev && scl === 1'b1) begin
            if (sdat === 1'b0) begin
                in_frame  = 1'b1;
                acking    = 1'b0;
                ack_drive = 1'b0;
                bitcnt    = 0;
                byte_num  = 0;
                n_starts++;
                last_start_cyc = cyc;
            end else begin
                in_frame = 1'b0;
                n_stops++;
            end
        end
        scl_prev = scl;
        sda_prev = sdat;
    end

    // Releases reset and runs the table to completion, checking framing and timing.
    task automatic run_to_done(input int frames, input logic exp_err);
        int base_s, base_p, rel, first, i;
        base_s = n_starts;
        base_p = n_stops;
        @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        i = 0;
        while (n_starts == base_s && i < 100 * D) begin
            @(negedge clk);
            i++;
        end
        check("first_start_seen", {31'h0, n_starts != base_s}, 32'h1);
        first = last_start_cyc;
        check_range("start_latency", first - rel, 4 * D, 8 * D);
        i = 0;
        while (!done && i < frames * 120 * D + 200 * D) begin
            @(negedge clk);
            i++;
        end
        check("config_done", {31'h0, done}, 32'h1);
        check_range("done_latency", cyc - first, frames * 120 * D - 6 * D, frames * 120 * D + 4 * D);
        check("ack_error", {31'h0, err}, {31'h0, exp_err});
        check("starts", n_starts - base_s, frames);
        check("stops", n_stops - base_p, frames);
        check("bytes_left", sb.size(), 0);
        check("done_state", {28'h0, cs}, 32'd10);
        check("done_scl", {31'h0, scl}, 32'h1);
        check("done_sda", {31'h0, sdat}, 32'h1);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int i;
        int base_s;
        logic hit;

        // Reset state
        repeat (3) begin
            repeat (2) @(negedge clk);
            check("rst_scl", {31'h0, scl}, 32'h1);
            check("rst_sda", {31'h0, sdat}, 32'h1);
            check("rst_done", {31'h0, done}, 32'h0);
            check("rst_err", {31'h0, err}, 32'h0);
            check("rst_state", {28'h0, cs}, 32'h0);
        end

        // Full table, all ACKed
        for (int w = 0; w < 11; w++) push_word(w);
        run_to_done(11, 1'b0);

        // NACK on the second word's LO byte
        nack_frame = n_starts + 2;
        push_word(0);
        push_word(1);
`ifdef I2C_ACK_RETRY_EN
        push_word(1);
`endif
        for (int w = 2; w < 11; w++) push_word(w);
`ifdef I2C_ACK_RETRY_EN
        run_to_done(12, 1'b1);
`else
        run_to_done(11, 1'b1);
`endif
        nack_frame = -1;

        // Reset in the middle of word 4's address byte
        push_word(0);
        push_word(1);
        push_word(2);
        base_s = n_starts;
        @(negedge clk);
        reset_n = 1'b1;
        i = 0;
        hit = 1'b0;
        while (!hit && i < 2000 * D) begin
            @(negedge clk);
            hit = (n_starts == base_s + 4) && (bitcnt == 3);
            i++;
        end
        check("reach_word4_addr", {31'h0, hit}, 32'h1);
        #3 reset_n = 1'b0;
        #1;
        check("midrst_scl", {31'h0, scl}, 32'h1);
        check("midrst_sda", {31'h0, sdat}, 32'h1);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_state", {28'h0, cs}, 32'h0);
        check("midrst_bytes_left", sb.size(), 0);
        #25000;
        for (int w = 0; w < 11; w++) push_word(w);
        run_to_done(11, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
